count_month: RTL and testbench
==============================

# count_month

Month stage of the century clock, directly downstream of the day counter. It holds the current month as two BCD digits (01–12) and advances on the day counter's end-of-month pulse. It decodes the month-length class (TO/T/TN) that the day counter uses to pick its wrap point, and emits a one-cycle end-of-year pulse to the year stage. In set mode it steps the month up or down on single presses.

## Interface
Parameters:
- MAX_DISPLAY_UNIT, 4, width of month_unit (BCD digit)
- MAX_DISPLAY_TEN, 1, width of month_ten (only values 0/1 legal)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset; synchronous, active-high
- en_m  input  1  1 = run mode (count on pulse_d); 0 = set mode (up/down stepping)
- pulse_d  input  1  end-of-month pulse from day stage; one cycle wide
- up  input  1  set-mode increment request, level; acted on at rising edge only
- down  input  1  set-mode decrement request, level; acted on at rising edge only
- month_unit  output  MAX_DISPLAY_UNIT  BCD units digit, registered
- month_ten  output  MAX_DISPLAY_TEN  BCD tens digit, registered
- TO  output  1  current month has 31 days (1,3,5,7,8,10,12)
- T  output  1  current month has 30 days (4,6,9,11)
- TN  output  1  current month is February
- pulse_m  output  1  end-of-year pulse to year stage; gated: pulse_year_reg & en_m

## Operation
- Month value M = 10*month_ten + month_unit. Legal range is 1..12.
- Run mode (en_m=1):
  - If pulse_d=1: M advances by one. 09→10 sets unit=0 and ten=1.
  - On 12→01, pulse_year_reg=1 for that cycle.
  - Any other cycle: pulse_year_reg=0. up/down are ignored.
- Set mode (en_m=0):
  - pulse_d is ignored. pulse_year_reg=0.
  - up_rise = up & ~up_q; down_rise = down & ~down_q. up_q and down_q are registered copies of up and down.
  - up_rise only: M+1, with 12→01 wrap. No pulse.
  - down_rise only: M−1, with 01→12 wrap. No pulse.
  - Both rises in the same cycle: no change.
  - Level held high: exactly one step per press.
- up_q and down_q update every cycle in both modes, so a press made during run mode does not step on entry to set mode.
- Class decode is combinational from the month registers and one-hot: exactly one of TO/T/TN is high for legal M.
- Illegal register contents:
  - Detected values: ten=1 with unit>2, ten=0 with unit=0, or unit>9.
  - Decode drives TO=T=TN=0.
  - Next clock edge forces M=01 regardless of mode or inputs. No pulse.

## Timing
- Reset, with rst high at an edge: month_unit=1, month_ten=0, pulse_year_reg=0, up_q=1, down_q=1. A key held through reset does not step.
- Reset outputs: TO=1, T=0, TN=0, pulse_m=0. rst overrides every other input.
- pulse_d sampled at edge N → new M visible after edge N, so TO/T/TN change in cycle N+1.
  - Relative to the day stage, whose day wrap coincides with pulse_d, the class updates one cycle after the day wrap.
  - The day counter is at 01/02 during that cycle, so the lag is harmless.
- pulse_m is high for exactly the one cycle in which M first reads 01 after 12. It is low if en_m drops in that cycle.
- Set-mode step latency: up rises before edge N → M changes after edge N. Nothing happens on the falling edge of up.
- pulse_d asserted on consecutive cycles: one step per cycle, no loss.
- rst asserted mid-pulse: pulse_m=0 from the next cycle.

## Structure
- Shared package clock_pkg holds:
  - MONTH_MIN=1 and MONTH_MAX=12 constants.
  - BCD digit width constants.
  - The localparam month list for the 31/30/28-day classes, shared with count_day and the year stage.
- Sub-module month_class_decode (combinational):
  - Inputs: month_ten, month_unit.
  - Outputs: TO, T, TN, illegal.
  - Instantiated once. The testbench reuses it as a reference model.
- The top contains the BCD up/down counter, edge detectors and pulse register.

## Test plan
- Reset: rst=1 for 2 cycles with up=1 held → M=01, TO=1, pulse_m=0. After release with up still high, M stays 01.
- Run rollover: en_m=1, preload M=12 via set mode, pulse_d one cycle → next cycle M=01, pulse_m=1 for one cycle, TO=1.
- Run sweep: 12 pulse_d pulses from 01 → sequence 02..12,01. TN only at 02; T at 04/06/09/11; 09→10 gives unit=0, ten=1. pulse_m exactly once.
- Set mode: en_m=0, down pressed once at M=01 → M=12, no pulse_m. up held 10 cycles → single step to 01. up and down rising together → no change.
- Mode gating: en_m=0 with pulse_d=1 → M unchanged. up pulsed while en_m=1, then en_m=0 with up still high → no step.
- Illegal recovery: force month_ten=1, month_unit=5 → that cycle TO=T=TN=0; next cycle M=01, TO=1.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the century-clock counter stages.
// Holds the legal month range, the BCD digit widths and the month-length
// class lists used by the day, month and year stages.
package clock_pkg;

  localparam int MONTH_MIN  = 1;
  localparam int MONTH_MAX  = 12;

  localparam int BCD_UNIT_W = 4;
  localparam int BCD_TEN_W  = 1;

  // Bit (m-1) is set when month m belongs to the class.
  localparam logic [11:0] MONTHS_31 = 12'b1010_1101_0101; // 1,3,5,7,8,10,12
  localparam logic [11:0] MONTHS_30 = 12'b0101_0010_1000; // 4,6,9,11
  localparam logic [11:0] MONTHS_28 = 12'b0000_0000_0010; // 2

endpackage

// File: rtl/month_class_decode.sv
// Combinational month-length class decoder.
// Ports:
//   month_ten  - BCD tens digit of the month (0/1)
//   month_unit - BCD units digit of the month
//   TO         - month has 31 days
//   T          - month has 30 days
//   TN         - month is February
//   illegal    - digits do not form a month in 1..12; all class outputs low
module month_class_decode
  import clock_pkg::*;
(
  input  logic [BCD_TEN_W-1:0]  month_ten,
  input  logic [BCD_UNIT_W-1:0] month_unit,
  output logic                  TO,
  output logic                  T,
  output logic                  TN,
  output logic                  illegal
);

  logic [4:0] month_bin;
  logic [3:0] idx;

  always_comb begin
    illegal = (month_unit > BCD_UNIT_W'(9))
           || ((month_ten == BCD_TEN_W'(0)) && (month_unit == BCD_UNIT_W'(0)))
           || ((month_ten != BCD_TEN_W'(0)) && (month_unit > BCD_UNIT_W'(2)));
    month_bin = ((month_ten != BCD_TEN_W'(0)) ? 5'd10 : 5'd0) + 5'(month_unit);
    // idx is only meaningful for legal months; illegal gates every output.
    idx = 4'(month_bin - 5'd1);
    TO  = !illegal && MONTHS_31[idx];
    T   = !illegal && MONTHS_30[idx];
    TN  = !illegal && MONTHS_28[idx];
  end

endmodule

// File: rtl/count_month.sv
// Month stage of the century clock.
// Counts months 01..12 in BCD, advancing on the day stage's end-of-month
// pulse in run mode, or stepping up/down on single key presses in set mode.
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset (month -> 01)
//   en_m       - 1 = run mode, 0 = set mode
//   pulse_d    - end-of-month pulse from the day stage
//   up, down   - set-mode step keys (level, acted on at rising edge)
//   month_unit - BCD units digit (registered)
//   month_ten  - BCD tens digit (registered)
//   TO, T, TN  - 31-day / 30-day / February class of the current month
//   pulse_m    - one-cycle end-of-year pulse to the year stage
module count_month
  import clock_pkg::*;
#(
  parameter int MAX_DISPLAY_UNIT = 4,
  parameter int MAX_DISPLAY_TEN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_m,
  input  logic                        pulse_d,
  input  logic                        up,
  input  logic                        down,
  output logic [MAX_DISPLAY_UNIT-1:0] month_unit,
  output logic [MAX_DISPLAY_TEN-1:0]  month_ten,
  output logic                        TO,
  output logic                        T,
  output logic                        TN,
  output logic                        pulse_m
);

  localparam int MW = MAX_DISPLAY_TEN + MAX_DISPLAY_UNIT;

  typedef logic [MW-1:0] month_t;

  localparam month_t M_01 = {MAX_DISPLAY_TEN'(0), MAX_DISPLAY_UNIT'(MONTH_MIN)};
  localparam month_t M_12 = {MAX_DISPLAY_TEN'(1), MAX_DISPLAY_UNIT'(MONTH_MAX - 10)};

  logic   up_p0;
  logic   down_p0;
  logic   pulse_year_p0;
  logic   illegal;
  logic   up_rise;
  logic   down_rise;
  month_t cur;

  function automatic month_t bcd_inc(input month_t m);
    logic [MAX_DISPLAY_TEN-1:0]  ten;
    logic [MAX_DISPLAY_UNIT-1:0] unit;
    month_t                      r;
    ten  = m[MW-1 -: MAX_DISPLAY_TEN];
    unit = m[MAX_DISPLAY_UNIT-1:0];
    if (m == M_12)
      r = M_01;
    else if (unit == MAX_DISPLAY_UNIT'(9))
      r = {MAX_DISPLAY_TEN'(1), MAX_DISPLAY_UNIT'(0)};
    else
      r = {ten, unit + MAX_DISPLAY_UNIT'(1)};
    return r;
  endfunction

  function automatic month_t bcd_dec(input month_t m);
    logic [MAX_DISPLAY_TEN-1:0]  ten;
    logic [MAX_DISPLAY_UNIT-1:0] unit;
    month_t                      r;
    ten  = m[MW-1 -: MAX_DISPLAY_TEN];
    unit = m[MAX_DISPLAY_UNIT-1:0];
    if (m == M_01)
      r = M_12;
    else if (unit == MAX_DISPLAY_UNIT'(0))
      r = {MAX_DISPLAY_TEN'(0), MAX_DISPLAY_UNIT'(9)};
    else
      r = {ten, unit - MAX_DISPLAY_UNIT'(1)};
    return r;
  endfunction

  assign cur       = {month_ten, month_unit};
  assign up_rise   = up & ~up_p0;
  assign down_rise = down & ~down_p0;

  month_class_decode u_decode (
    .month_ten  (month_ten),
    .month_unit (month_unit),
    .TO         (TO),
    .T          (T),
    .TN         (TN),
    .illegal    (illegal)
  );

  // ---- stage p0: month register, key history, end-of-year pulse ----
  // Key history resets high so a key held through reset is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      {month_ten, month_unit} <= M_01;
      pulse_year_p0           <= 1'b0;
      up_p0                   <= 1'b1;
      down_p0                 <= 1'b1;
    end else begin
      up_p0         <= up;
      down_p0       <= down;
      pulse_year_p0 <= 1'b0;
      if (illegal) begin
        {month_ten, month_unit} <= M_01;
      end else if (en_m) begin
        if (pulse_d) begin
          {month_ten, month_unit} <= bcd_inc(cur);
          pulse_year_p0           <= (cur == M_12);
        end
      end else if (up_rise && !down_rise) begin
        {month_ten, month_unit} <= bcd_inc(cur);
      end else if (down_rise && !up_rise) begin
        {month_ten, month_unit} <= bcd_dec(cur);
      end
    end
  end

  assign pulse_m = pulse_year_p0 & en_m;

endmodule

// File: tb/tb_count_month.sv
module tb_count_month;

  logic       clk;
  logic       rst;
  logic       en_m;
  logic       pulse_d;
  logic       up;
  logic       down;
  logic [3:0] month_unit;
  logic [0:0] month_ten;
  logic       TO;
  logic       T;
  logic       TN;
  logic       pulse_m;

  logic [3:0] ref_unit;
  logic [0:0] ref_ten;
  logic       ref_to;
  logic       ref_t;
  logic       ref_tn;
  logic       ref_ill;

  int n_cmp  = 0;
  int n_fail = 0;

  count_month #(.MAX_DISPLAY_UNIT(4), .MAX_DISPLAY_TEN(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .en_m       (en_m),
    .pulse_d    (pulse_d),
    .up         (up),
    .down       (down),
    .month_unit (month_unit),
    .month_ten  (month_ten),
    .TO         (TO),
    .T          (T),
    .TN         (TN),
    .pulse_m    (pulse_m)
  );

  month_class_decode u_ref (
    .month_ten  (ref_ten),
    .month_unit (ref_unit),
    .TO         (ref_to),
    .T          (ref_t),
    .TN         (ref_tn),
    .illegal    (ref_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en_m;
    logic       pulse_d;
    logic       up;
    logic       down;
    logic [3:0] unit;
    logic       ten;
    logic       to;
    logic       t;
    logic       tn;
    logic       pm;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic e, input logic p, input logic u, input logic d,
                              input int mu, input int mt,
                              input logic to, input logic t, input logic tn, input logic pm);
    vec_t v;
    v.en_m = e; v.pulse_d = p; v.up = u; v.down = d;
    v.unit = 4'(mu); v.ten = 1'(mt);
    v.to = to; v.t = t; v.tn = tn; v.pm = pm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_month(input string name, input int mu, input int mt);
    chk({name, " unit"}, 32'(month_unit), 32'(mu));
    chk({name, " ten"}, 32'(month_ten), 32'(mt));
  endtask

  initial begin
    // Reset with up held high.
    rst = 1'b1; en_m = 1'b1; pulse_d = 1'b0; up = 1'b1; down = 1'b0;
    ref_unit = 4'd1; ref_ten = 1'b0;
    tick();
    tick();
    chk_month("reset", 1, 0);
    chk("reset class", 32'({TO, T, TN}), 32'(3'b100));
    chk("reset pulse_m", 32'(pulse_m), 32'd0);
    rst = 1'b0; en_m = 1'b0;
    tick();
    chk_month("up held past reset", 1, 0);

    //            en pd up dn  unit ten  TO T TN pm
    vecs[0]  = mk(0, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 1,  2, 1,  1, 0, 0, 0); // down at 01 -> 12
    vecs[2]  = mk(0, 0, 0, 0,  2, 1,  1, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0,  1, 0,  1, 0, 0, 1); // 12 -> 01 rollover
    vecs[4]  = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    vecs[5]  = mk(1, 1, 0, 0,  2, 0,  0, 0, 1, 0);
    vecs[6]  = mk(1, 1, 0, 0,  3, 0,  1, 0, 0, 0);
    vecs[7]  = mk(1, 1, 0, 0,  4, 0,  0, 1, 0, 0);
    vecs[8]  = mk(1, 1, 0, 0,  5, 0,  1, 0, 0, 0);
    vecs[9]  = mk(1, 1, 0, 0,  6, 0,  0, 1, 0, 0);
    vecs[10] = mk(1, 1, 0, 0,  7, 0,  1, 0, 0, 0);
    vecs[11] = mk(1, 1, 0, 0,  8, 0,  1, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 0,  9, 0,  0, 1, 0, 0);
    vecs[13] = mk(1, 1, 0, 0,  0, 1,  1, 0, 0, 0); // 09 -> 10
    vecs[14] = mk(1, 1, 0, 0,  1, 1,  0, 1, 0, 0);
    vecs[15] = mk(1, 1, 0, 0,  2, 1,  1, 0, 0, 0);
    vecs[16] = mk(1, 1, 0, 0,  1, 0,  1, 0, 0, 1); // end of year
    vecs[17] = mk(1, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    vecs[18] = mk(0, 1, 0, 0,  1, 0,  1, 0, 0, 0); // pulse_d ignored in set mode
    vecs[19] = mk(0, 0, 1, 0,  2, 0,  0, 0, 1, 0); // up press
    vecs[20] = mk(0, 0, 1, 0,  2, 0,  0, 0, 1, 0);
    vecs[21] = mk(0, 0, 0, 0,  2, 0,  0, 0, 1, 0);
    vecs[22] = mk(0, 0, 1, 1,  2, 0,  0, 0, 1, 0); // both rise together
    vecs[23] = mk(0, 0, 0, 0,  2, 0,  0, 0, 1, 0);
    vecs[24] = mk(0, 0, 0, 1,  1, 0,  1, 0, 0, 0); // down press
    vecs[25] = mk(0, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    vecs[26] = mk(1, 0, 1, 0,  1, 0,  1, 0, 0, 0); // up ignored in run mode
    vecs[27] = mk(0, 0, 1, 0,  1, 0,  1, 0, 0, 0); // still high: no step
    vecs[28] = mk(0, 0, 0, 0,  1, 0,  1, 0, 0, 0);
    vecs[29] = mk(0, 0, 0, 1,  2, 1,  1, 0, 0, 0);
    vecs[30] = mk(0, 0, 0, 0,  2, 1,  1, 0, 0, 0);

    for (int i = 0; i < 31; i++) begin
      en_m = vecs[i].en_m; pulse_d = vecs[i].pulse_d;
      up = vecs[i].up; down = vecs[i].down;
      ref_unit = vecs[i].unit; ref_ten = vecs[i].ten;
      tick();
      chk_month($sformatf("v%0d", i), int'(vecs[i].unit), int'(vecs[i].ten));
      chk($sformatf("v%0d class", i), 32'({TO, T, TN}),
          32'({vecs[i].to, vecs[i].t, vecs[i].tn}));
      chk($sformatf("v%0d class vs ref", i), 32'({TO, T, TN}), 32'({ref_to, ref_t, ref_tn}));
      chk($sformatf("v%0d pulse_m", i), 32'(pulse_m), 32'(vecs[i].pm));
    end

    // up held for 10 cycles at 12: exactly one step, to 01.
    en_m = 1'b0; pulse_d = 1'b0; up = 1'b1; down = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_month($sformatf("held up c%0d", k), 1, 0);
      chk($sformatf("held up c%0d pulse_m", k), 32'(pulse_m), 32'd0);
    end
    up = 1'b0;
    tick();

    // Preload 12, roll over, then drop en_m in the pulse cycle.
    down = 1'b1; tick(); down = 1'b0; tick();
    chk_month("preload 12", 2, 1);
    en_m = 1'b1; pulse_d = 1'b1;
    tick();
    pulse_d = 1'b0;
    chk("rollover pulse_m", 32'(pulse_m), 32'd1);
    en_m = 1'b0;
    #1;
    chk("pulse_m gated by en_m", 32'(pulse_m), 32'd0);
    en_m = 1'b1;
    #1;
    chk("pulse_m re-enabled", 32'(pulse_m), 32'd1);
    // Reset in the middle of the pulse.
    rst = 1'b1;
    tick();
    chk("pulse_m after mid reset", 32'(pulse_m), 32'd0);
    chk_month("mid reset", 1, 0);
    rst = 1'b0;
    tick();

    // Illegal register contents 15.
    force dut.month_ten  = 1'b1;
    force dut.month_unit = 4'd5;
    #1;
    chk("illegal class", 32'({TO, T, TN}), 32'd0);
    release dut.month_ten;
    release dut.month_unit;
    #1;
    tick();
    chk_month("illegal recovery", 1, 0);
    chk("illegal recovery TO", 32'(TO), 32'd1);
    chk("illegal recovery pulse_m", 32'(pulse_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
